sc_cfg_loader: RTL and testbench

- Upstream feeder for the SKIROC2 slow-control shifter.
- Takes the 16-bit command word stream from the USB command interpreter and recognises a slow-control frame: header, data words, trailer.
- Unpacks each data word into bytes, MSB byte first, and writes them into the external 8-bit SC FIFO.
- On a valid trailer, pulses the shifter's start input and waits for its end-of-configuration pulse. On any frame error it flushes the FIFO and raises a sticky error.

---
 rtl/sc_pkg.sv | 32 +++
 rtl/sc_cfg_loader_if.sv | 31 +++
 rtl/sc_cfg_loader.sv | 169 ++++++++++++++++
 tb/tb_sc_cfg_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared constants for the SKIROC2 slow-control path: frame words, payload size,
// loader FSM encoding and error codes. The shifter sizes its bit count from SC_BYTES too.
package sc_pkg;

  localparam int SC_BYTES    = 77;
  localparam int SC_BITS     = SC_BYTES * 8;
  localparam int SC_WORDS    = (SC_BYTES + 1) / 2;
  localparam int TIMEOUT_CYC = 4096;

  localparam logic [15:0] HDR_WORD = 16'hA5C3;
  localparam logic [15:0] TRL_WORD = 16'h5A3C;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TRAILER  = 2'b01,
    ERR_OVERFLOW = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_t;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HDR_FLUSH = 4'd1,
    ST_DATA_HI   = 4'd2,
    ST_DATA_LO   = 4'd3,
    ST_TRAILER   = 4'd4,
    ST_START     = 4'd5,
    ST_WAIT_END  = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } state_t;

endpackage

// File: rtl/sc_cfg_loader_if.sv
// Bundles the command stream, SC FIFO write port, shifter handshake and status
// of the slow-control loader. slave = loader side, master = its environment.
interface sc_cfg_loader_if;

  logic [15:0] In_Cmd_Data;
  logic        In_Cmd_Valid;
  logic        Out_Cmd_Ready;
  logic [7:0]  Out_Fifo_Din;
  logic        Out_Fifo_Wr_En;
  logic        In_Fifo_Full;
  logic        Out_Fifo_Rst;
  logic        Out_Sc_Start;
  logic        In_End_SC;
  logic        Out_Busy;
  logic        Out_Done;
  logic        Out_Err;
  logic [1:0]  Out_Err_Code;

  modport slave (
    input  In_Cmd_Data, In_Cmd_Valid, In_Fifo_Full, In_End_SC,
    output Out_Cmd_Ready, Out_Fifo_Din, Out_Fifo_Wr_En, Out_Fifo_Rst,
           Out_Sc_Start, Out_Busy, Out_Done, Out_Err, Out_Err_Code
  );

  modport master (
    output In_Cmd_Data, In_Cmd_Valid, In_Fifo_Full, In_End_SC,
    input  Out_Cmd_Ready, Out_Fifo_Din, Out_Fifo_Wr_En, Out_Fifo_Rst,
           Out_Sc_Start, Out_Busy, Out_Done, Out_Err, Out_Err_Code
  );

endinterface

// File: rtl/sc_cfg_loader.sv
// Slow-control frame loader: checks HDR/data/TRL framing, unpacks words MSB byte first
// into the SC FIFO, then kicks the shifter and waits for its end-of-configuration pulse.
module sc_cfg_loader
  import sc_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_N,
  sc_cfg_loader_if.slave    bus
);

  localparam logic [7:0]       LAST_BYTE = 8'(SC_BYTES);
  localparam int               TMO_W     = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [7:0]       r_byteCnt;
  logic [7:0]       r_loByte;
  logic             r_startPh;
  logic [TMO_W-1:0] r_tmoCnt;
  logic             r_err;
  err_code_t        r_errCode;
  logic             r_live;

  state_t           w_next;
  logic [7:0]       w_byteCntNxt;
  logic [7:0]       w_loByteNxt;
  logic             w_startPhNxt;
  logic [TMO_W-1:0] w_tmoNxt;
  logic             w_errNxt;
  err_code_t        w_codeNxt;
  logic             w_ready;
  logic             w_wrEn;
  logic [7:0]       w_din;
  logic             w_fifoRst;
  logic             w_scStart;
  logic             w_done;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state   <= ST_IDLE;
      r_byteCnt <= '0;
      r_loByte  <= '0;
      r_startPh <= 1'b0;
      r_tmoCnt  <= '0;
      r_err     <= 1'b0;
      r_errCode <= ERR_NONE;
      r_live    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_byteCnt <= w_byteCntNxt;
      r_loByte  <= w_loByteNxt;
      r_startPh <= w_startPhNxt;
      r_tmoCnt  <= w_tmoNxt;
      r_err     <= w_errNxt;
      r_errCode <= w_codeNxt;
      r_live    <= 1'b1;
    end
  end

  // r_live keeps Ready low while reset is held and for the first edge after release.
  always_comb begin
    w_next       = r_state;
    w_byteCntNxt = r_byteCnt;
    w_loByteNxt  = r_loByte;
    w_startPhNxt = r_startPh;
    w_tmoNxt     = r_tmoCnt;
    w_errNxt     = r_err;
    w_codeNxt    = r_errCode;
    w_ready      = 1'b0;
    w_wrEn       = 1'b0;
    w_din        = '0;
    w_fifoRst    = 1'b0;
    w_scStart    = 1'b0;
    w_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ready = r_live;
        if (w_ready && bus.In_Cmd_Valid && bus.In_Cmd_Data == HDR_WORD) begin
          w_errNxt     = 1'b0;
          w_codeNxt    = ERR_NONE;
          w_byteCntNxt = '0;
          w_next       = ST_HDR_FLUSH;
        end
      end
      ST_HDR_FLUSH: begin
        w_fifoRst = 1'b1;
        w_next    = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        w_ready = !bus.In_Fifo_Full;
        if (w_ready && bus.In_Cmd_Valid) begin
          w_wrEn       = 1'b1;
          w_din        = bus.In_Cmd_Data[15:8];
          w_loByteNxt  = bus.In_Cmd_Data[7:0];
          w_byteCntNxt = r_byteCnt + 8'd1;
          w_next       = (w_byteCntNxt == LAST_BYTE) ? ST_TRAILER : ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (!bus.In_Fifo_Full) begin
          w_wrEn       = 1'b1;
          w_din        = r_loByte;
          w_byteCntNxt = r_byteCnt + 8'd1;
          w_next       = (w_byteCntNxt == LAST_BYTE) ? ST_TRAILER : ST_DATA_HI;
        end
      end
      ST_TRAILER: begin
        w_ready = 1'b1;
        if (bus.In_Cmd_Valid) begin
          if (bus.In_Cmd_Data == TRL_WORD) begin
            w_next = ST_START;
          end else begin
            w_next    = ST_ERROR;
            w_codeNxt = ERR_TRAILER;
          end
        end
      end
      ST_START: begin
        w_scStart = 1'b1;
        if (r_startPh) begin
          w_startPhNxt = 1'b0;
          w_tmoNxt     = '0;
          w_next       = ST_WAIT_END;
        end else begin
          w_startPhNxt = 1'b1;
        end
      end
      ST_WAIT_END: begin
        if (bus.In_End_SC) begin
          w_next = ST_DONE;
        end else if (r_tmoCnt == TMO_LAST) begin
          w_next    = ST_ERROR;
          w_codeNxt = ERR_TIMEOUT;
        end else begin
          w_tmoNxt = r_tmoCnt + TMO_W'(1);
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERROR: begin
        w_fifoRst = 1'b1;
        w_errNxt  = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase

    // Guard against a FIFO that lies about its full flag.
    if (w_wrEn && bus.In_Fifo_Full) begin
      w_wrEn    = 1'b0;
      w_next    = ST_ERROR;
      w_codeNxt = ERR_OVERFLOW;
    end
  end

  assign bus.Out_Cmd_Ready  = w_ready;
  assign bus.Out_Fifo_Din   = w_din;
  assign bus.Out_Fifo_Wr_En = w_wrEn;
  assign bus.Out_Fifo_Rst   = w_fifoRst;
  assign bus.Out_Sc_Start   = w_scStart;
  assign bus.Out_Busy       = (r_state != ST_IDLE);
  assign bus.Out_Done       = w_done;
  assign bus.Out_Err        = r_err;
  assign bus.Out_Err_Code   = r_errCode;

endmodule

// File: tb/tb_sc_cfg_loader.sv
// Scenario bench for sc_cfg_loader: expected FIFO bytes are queued as words are driven
// and popped by a negedge monitor whenever the loader writes.
`timescale 1ns/1ps
module tb_sc_cfg_loader;
  import sc_pkg::*;

  logic Clk = 1'b0;
  logic Rst_N;

  sc_cfg_loader_if bus();

  sc_cfg_loader dut (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .bus   (bus)
  );

  always #100 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] expQ[$];
  logic [7:0] expByte;
  int wrCount = 0;
  int rstPulses = 0;
  int startHigh = 0;

  // Monitor: outputs sampled mid-cycle describe the transfer at the coming posedge.
  always @(negedge Clk) begin
    if (bus.Out_Fifo_Wr_En === 1'b1) begin
      wrCount++;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL fifo_byte unexpected write got=%02h want=none", bus.Out_Fifo_Din);
      end else begin
        expByte = expQ.pop_front();
        if (bus.Out_Fifo_Din !== expByte) begin
          failures++;
          $display("[TB] FAIL fifo_byte got=%02h want=%02h", bus.Out_Fifo_Din, expByte);
        end
      end
    end
    if (bus.Out_Fifo_Rst === 1'b1) rstPulses++;
    if (bus.Out_Sc_Start === 1'b1) startHigh++;
  end

  initial begin
    #(200 * 60000);
    $display("[TB] FAIL watchdog simulation did not finish got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_word(input logic [15:0] w, output bit ok);
    bit acc;
    ok = 1'b0;
    bus.In_Cmd_Data  = w;
    bus.In_Cmd_Valid = 1'b1;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge Clk);
      acc = (bus.Out_Cmd_Ready === 1'b1);
      @(posedge Clk);
      #20;
      if (acc) ok = 1'b1;
    end
    bus.In_Cmd_Valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd_accept word=%04h got=not_accepted want=accepted", w);
    end
  endtask

  task automatic send_payload(input int mode, output bit ok);
    logic [7:0] hi;
    logic [7:0] lo;
    send_word(HDR_WORD, ok);
    for (int i = 0; i < SC_WORDS && ok; i++) begin
      if (mode == 0) begin
        hi = 8'(2 * i);
        lo = (2 * i + 1 < SC_BYTES) ? 8'(2 * i + 1) : 8'hFF;
      end else begin
        hi = HDR_WORD[15:8];
        lo = HDR_WORD[7:0];
      end
      expQ.push_back(hi);
      if (2 * i + 1 < SC_BYTES) expQ.push_back(lo);
      send_word({hi, lo}, ok);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    @(negedge Clk);
    while (bus.Out_Sc_Start === 1'b1 && n < 10) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic pulse_end_sc();
    @(posedge Clk); #20;
    bus.In_End_SC = 1'b1;
    @(posedge Clk); #20;
    bus.In_End_SC = 1'b0;
  endtask

  task automatic test_reset();
    bus.In_Cmd_Data  = '0;
    bus.In_Cmd_Valid = 1'b0;
    bus.In_Fifo_Full = 1'b0;
    bus.In_End_SC    = 1'b0;
    Rst_N = 1'b0;
    #50;
    checks++;
    if ({bus.Out_Cmd_Ready, bus.Out_Fifo_Wr_En, bus.Out_Fifo_Rst, bus.Out_Sc_Start, bus.Out_Busy,
         bus.Out_Done, bus.Out_Err, bus.Out_Err_Code, bus.Out_Fifo_Din} !== 17'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=rdy%b wr%b rst%b st%b busy%b done%b err%b code%b din%02h want=all_zero",
               bus.Out_Cmd_Ready, bus.Out_Fifo_Wr_En, bus.Out_Fifo_Rst, bus.Out_Sc_Start, bus.Out_Busy,
               bus.Out_Done, bus.Out_Err, bus.Out_Err_Code, bus.Out_Fifo_Din);
    end
    #300;
    Rst_N = 1'b1;
    @(posedge Clk); #20;
    @(negedge Clk);
    checks++;
    if (bus.Out_Cmd_Ready !== 1'b1 || bus.Out_Busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_idle got=rdy%b busy%b want=rdy1 busy0", bus.Out_Cmd_Ready, bus.Out_Busy);
    end
    @(posedge Clk); #20;
  endtask

  task automatic test_garbage();
    int w0;
    int busySeen;
    bit ok;
    w0 = wrCount;
    busySeen = 0;
    send_word(16'h0000, ok);
    if (bus.Out_Busy !== 1'b0) busySeen++;
    send_word(16'hFFFF, ok);
    if (bus.Out_Busy !== 1'b0) busySeen++;
    pulse_end_sc();
    @(negedge Clk);
    if (bus.Out_Busy !== 1'b0) busySeen++;
    checks++;
    if (busySeen != 0) begin
      failures++;
      $display("[TB] FAIL garbage_busy got=%0d busy_samples want=0", busySeen);
    end
    checks++;
    if (wrCount != w0) begin
      failures++;
      $display("[TB] FAIL garbage_writes got=%0d want=0", wrCount - w0);
    end
    checks++;
    if (bus.Out_Err !== 1'b0 || bus.Out_Done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL garbage_err_done got=err%b done%b want=err0 done0", bus.Out_Err, bus.Out_Done);
    end
    @(posedge Clk); #20;
  endtask

  task automatic run_good_frame(input int mode, input string tag);
    int w0;
    int r0;
    int n;
    bit ok;
    w0 = wrCount;
    r0 = rstPulses;
    send_payload(mode, ok);
    send_word(TRL_WORD, ok);
    wait_start(n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("[TB] FAIL %s start_cycles got=%0d want=2", tag, n);
    end
    checks++;
    if (wrCount - w0 != SC_BYTES || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s byte_count got=%0d left=%0d want=%0d left=0", tag, wrCount - w0, expQ.size(), SC_BYTES);
    end
    checks++;
    if (rstPulses - r0 != 1) begin
      failures++;
      $display("[TB] FAIL %s hdr_flush got=%0d want=1", tag, rstPulses - r0);
    end
    pulse_end_sc();
    @(negedge Clk);
    checks++;
    if (bus.Out_Done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s done_pulse got=%b want=1", tag, bus.Out_Done);
    end
    @(negedge Clk);
    checks++;
    if (bus.Out_Done !== 1'b0 || bus.Out_Busy !== 1'b0 || bus.Out_Err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s after_done got=done%b busy%b err%b want=0 0 0", tag, bus.Out_Done, bus.Out_Busy, bus.Out_Err);
    end
    @(posedge Clk); #20;
  endtask

  task automatic test_nominal();
    run_good_frame(0, "nominal");
  endtask

  task automatic test_hdr_as_data();
    run_good_frame(1, "hdr_as_data");
  endtask

  task automatic test_bad_trailer();
    int r0;
    int s0;
    bit ok;
    send_payload(0, ok);
    r0 = rstPulses;
    s0 = startHigh;
    send_word(16'h1234, ok);
    repeat (3) @(negedge Clk);
    checks++;
    if (bus.Out_Err !== 1'b1 || bus.Out_Err_Code !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bad_trailer_err got=err%b code%b want=err1 code01", bus.Out_Err, bus.Out_Err_Code);
    end
    checks++;
    if (rstPulses - r0 != 1 || startHigh != s0) begin
      failures++;
      $display("[TB] FAIL bad_trailer_flush got=rst%0d start%0d want=rst1 start0", rstPulses - r0, startHigh - s0);
    end
    checks++;
    if (expQ.size() != 0 || bus.Out_Busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bad_trailer_bytes got=left%0d busy%b want=left0 busy0", expQ.size(), bus.Out_Busy);
    end
    @(posedge Clk); #20;
  endtask

  task automatic test_backpressure();
    int w0;
    int viol;
    int waitN;
    int n;
    bit ok;
    w0 = wrCount;
    viol = 0;
    waitN = 0;
    fork
      begin
        send_payload(0, ok);
        send_word(TRL_WORD, ok);
      end
      begin
        while (wrCount - w0 < 20 && waitN < 2000) begin
          @(posedge Clk);
          waitN++;
        end
        #20;
        bus.In_Fifo_Full = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge Clk);
          if (bus.Out_Cmd_Ready !== 1'b0 || bus.Out_Fifo_Wr_En !== 1'b0) viol++;
        end
        checks++;
        if (wrCount - w0 != 20) begin
          failures++;
          $display("[TB] FAIL backpressure_hold_count got=%0d want=20", wrCount - w0);
        end
        @(posedge Clk); #20;
        bus.In_Fifo_Full = 1'b0;
      end
    join
    checks++;
    if (viol != 0) begin
      failures++;
      $display("[TB] FAIL backpressure_stall got=%0d active_cycles want=0", viol);
    end
    wait_start(n);
    checks++;
    if (wrCount - w0 != SC_BYTES || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL backpressure_count got=%0d left=%0d want=%0d left=0", wrCount - w0, expQ.size(), SC_BYTES);
    end
    pulse_end_sc();
    @(negedge Clk);
    checks++;
    if (bus.Out_Done !== 1'b1 || bus.Out_Err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL backpressure_done got=done%b err%b want=done1 err0", bus.Out_Done, bus.Out_Err);
    end
    @(posedge Clk); #20;
  endtask

  task automatic test_timeout();
    int n;
    int k;
    bit ok;
    send_payload(0, ok);
    send_word(TRL_WORD, ok);
    wait_start(n);
    k = 1;
    while (bus.Out_Fifo_Rst !== 1'b1 && k < 6000) begin
      @(negedge Clk);
      k++;
    end
    checks++;
    if (k != TIMEOUT_CYC + 1) begin
      failures++;
      $display("[TB] FAIL timeout_cycles got=%0d want=%0d", k, TIMEOUT_CYC + 1);
    end
    @(negedge Clk);
    checks++;
    if (bus.Out_Err !== 1'b1 || bus.Out_Err_Code !== 2'b11 || bus.Out_Busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_err got=err%b code%b busy%b want=err1 code11 busy0",
               bus.Out_Err, bus.Out_Err_Code, bus.Out_Busy);
    end
    @(posedge Clk); #20;
    run_good_frame(0, "after_timeout");
  endtask

  task automatic test_async_reset();
    int w0;
    bit ok;
    send_word(HDR_WORD, ok);
    expQ.push_back(8'h12);
    expQ.push_back(8'h34);
    send_word(16'h1234, ok);
    #30;
    Rst_N = 1'b0;
    #1;
    checks++;
    if ({bus.Out_Cmd_Ready, bus.Out_Fifo_Wr_En, bus.Out_Fifo_Rst, bus.Out_Sc_Start,
         bus.Out_Busy, bus.Out_Done, bus.Out_Err} !== 7'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs got=rdy%b wr%b rst%b st%b busy%b done%b err%b want=all_zero",
               bus.Out_Cmd_Ready, bus.Out_Fifo_Wr_En, bus.Out_Fifo_Rst, bus.Out_Sc_Start,
               bus.Out_Busy, bus.Out_Done, bus.Out_Err);
    end
    @(posedge Clk); #20;
    expQ.delete();
    Rst_N = 1'b1;
    @(posedge Clk); #20;
    @(negedge Clk);
    checks++;
    if (bus.Out_Cmd_Ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reset_ready got=%b want=1", bus.Out_Cmd_Ready);
    end
    @(posedge Clk); #20;
    w0 = wrCount;
    send_word(16'h1111, ok);
    @(negedge Clk);
    checks++;
    if (bus.Out_Busy !== 1'b0 || wrCount != w0) begin
      failures++;
      $display("[TB] FAIL async_reset_ignore got=busy%b writes%0d want=busy0 writes0", bus.Out_Busy, wrCount - w0);
    end
    @(posedge Clk); #20;
  endtask

  initial begin
    $display("[TB] sc_cfg_loader bench start");
    test_reset();
    test_garbage();
    test_nominal();
    test_hdr_as_data();
    test_bad_trailer();
    test_backpressure();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
